// File: rtl/apb_modport_pkg.sv
// apb_modport_pkg: shared types and helpers for the APB completer slice.
//   apb_state_e  : completer FSM state (IDLE, ACCESS)
//   decode_err   : address/protection error decode for one transfer
//   apply_strb   : byte-lane merge of write data into an old register value
// Helpers operate on the widest supported bus (64 data bits, 8 strobes);
// callers zero-extend narrower values and truncate the result.
package apb_modport_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  // off   : number of byte-offset address bits (log2 of bytes per word)
  // idx_w : number of register-index address bits (log2 of register count)
  function automatic logic decode_err(input logic [63:0] addr,
                                      input logic [2:0]  prot,
                                      input logic        apb4_mode,
                                      input int unsigned off,
                                      input int unsigned idx_w);
    logic [63:0] lo_mask;
    logic        err;
    lo_mask = (64'd1 << off) - 64'd1;
    err = ((addr & lo_mask) != 64'd0);               // misaligned
    if ((addr >> (off + idx_w)) != 64'd0) err = 1'b1; // beyond the bank
    // Non-secure access to the upper (secure) half: top index bit set.
    if (apb4_mode && prot[1] && addr[off + idx_w - 1]) err = 1'b1;
    return err;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] apply_strb(
      input logic [MAX_DATA_W-1:0] old,
      input logic [MAX_DATA_W-1:0] wdata,
      input logic [MAX_STRB_W-1:0] strb);
    logic [MAX_DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      if (strb[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_modport_if.sv
// apb_modport_if: APB3/APB4 bus signal group.
//   slave modport : samples PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB/PPROT,
//                   drives PRDATA/PREADY/PSLVERR
//   master modport: the mirror image
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
// access cycles (PSEL=1, PENABLE=1); it completes in the access cycle in
// which PREADY=1, and PSLVERR/PRDATA are only meaningful in that cycle.
interface apb_modport_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 1
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] PADDR;
  logic [NSEL-1:0]   PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [2:0]        PPROT;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_modport_regbank.sv
// apb_modport_regbank: NREGS x DATA_W register storage.
//   clk, rst          : clock, synchronous active-high clear
//   we/widx/wdata/wstrb : byte-enabled write port, commits on clk edge
//   ridx/rdata        : combinational read port
module apb_modport_regbank
  import apb_modport_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= DATA_W'(apply_strb(MAX_DATA_W'(mem[widx]),
                                      MAX_DATA_W'(wdata),
                                      MAX_STRB_W'(wstrb)));
    end
  end

  assign rdata = mem[ridx];
endmodule

// File: rtl/apb_modport_slave.sv
// apb_modport_slave: APB3/APB4 completer with a small register bank and a
// fixed number of wait states per access.
//   PCLK, PRESET : clock, synchronous active-high reset
//   apb4_mode    : 1 = honour PSTRB/PPROT, 0 = APB3 (full-word writes)
//   apb          : APB signal group, slave side
//   dbg_state    : current FSM state
module apb_modport_slave
  import apb_modport_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NSEL        = 1,
  parameter int SEL_IDX     = 0,
  parameter int NREGS       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        apb4_mode,
  apb_modport_if.slave apb,
  output apb_state_e  dbg_state
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NREGS);

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  // Setup-time snapshot; the error flag already folds in PPROT and mode,
  // so the raw protection bits need not be kept.
  logic [IDX_W-1:0]  idx_q;
  logic              err_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;

  logic              sel, setup, latch, we;
  logic              pready_c, pslverr_c;
  logic [DATA_W-1:0] prdata_c, rdata;

  assign sel   = apb.PSEL[SEL_IDX];
  assign setup = sel & ~apb.PENABLE;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        idx_q   <= apb.PADDR[OFF +: IDX_W];
        err_q   <= decode_err(64'(apb.PADDR), apb.PPROT, apb4_mode, OFF, IDX_W);
        write_q <= apb.PWRITE;
        wdata_q <= apb.PWDATA;
        strb_q  <= apb4_mode ? apb.PSTRB : '1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch     = 1'b0;
    we        = 1'b0;
    pready_c  = 1'b0;
    pslverr_c = 1'b0;
    prdata_c  = '0;
    case (state_q)
      IDLE: begin
        if (sel && apb.PENABLE) begin
          // Access phase with no setup: refuse at once, touch nothing.
          pready_c  = 1'b1;
          pslverr_c = 1'b1;
        end else if (setup) begin
          latch   = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_d = IDLE;                // deselect aborts, no write
        end else if (!apb.PENABLE) begin
          latch   = 1'b1;                // master restarted with a new setup
          cnt_d   = 4'(WAIT_STATES);
        end else if (cnt_q == 4'd0) begin
          pready_c  = 1'b1;
          pslverr_c = err_q;
          if (!write_q && !err_q) prdata_c = rdata;
          we        = write_q & ~err_q;
          // Back to IDLE: a setup in the next cycle is taken from there,
          // so back-to-back transfers need no idle cycle.
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  apb_modport_regbank #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regbank (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .ridx  (idx_q),
    .rdata (rdata)
  );

  // Outputs are held low for the whole time reset is asserted.
  assign apb.PREADY  = ~PRESET & pready_c;
  assign apb.PSLVERR = ~PRESET & pslverr_c;
  assign apb.PRDATA  = PRESET ? '0 : prdata_c;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_apb_modport_slave.sv
module tb_apb_modport_slave;
  import apb_modport_pkg::*;

  logic        PCLK, PRESET, apb4_mode;
  logic [31:0] paddr, pwdata;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  int          act;   // which completer the stimulus is aimed at
  int          total, bad;
  logic [31:0] mdl [2][16];
  int          ws [2];
  apb_state_e  dbg0, dbg1;
  logic        pready, pslverr;
  logic [31:0] prdata;

  apb_modport_if #(.ADDR_W(32), .DATA_W(32), .NSEL(1)) bus0 ();
  apb_modport_if #(.ADDR_W(32), .DATA_W(32), .NSEL(1)) bus1 ();

  assign bus0.PADDR = paddr;  assign bus1.PADDR = paddr;
  assign bus0.PENABLE = penable; assign bus1.PENABLE = penable;
  assign bus0.PWRITE = pwrite; assign bus1.PWRITE = pwrite;
  assign bus0.PWDATA = pwdata; assign bus1.PWDATA = pwdata;
  assign bus0.PSTRB = pstrb;  assign bus1.PSTRB = pstrb;
  assign bus0.PPROT = pprot;  assign bus1.PPROT = pprot;
  assign bus0.PSEL = psel && (act == 0);
  assign bus1.PSEL = psel && (act == 1);
  assign pready  = (act == 0) ? bus0.PREADY  : bus1.PREADY;
  assign pslverr = (act == 0) ? bus0.PSLVERR : bus1.PSLVERR;
  assign prdata  = (act == 0) ? bus0.PRDATA  : bus1.PRDATA;

  apb_modport_slave #(.WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .apb4_mode(apb4_mode), .apb(bus0), .dbg_state(dbg0));
  apb_modport_slave #(.WAIT_STATES(3)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .apb4_mode(apb4_mode), .apb(bus1), .dbg_state(dbg1));

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: error and merge rules written as plain arithmetic
  function automatic bit m_err(input logic [31:0] a, input logic [2:0] pr, input logic apb4);
    return (a % 4 != 0) || (a > 63) || (apb4 && pr[1] && ((a / 4) % 16) >= 8);
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  // driver tasks
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input bit mangle,
                      output logic [31:0] rd, output logic err, output int cyc);
    @(negedge PCLK);
    psel = 1; penable = 0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr;
    @(negedge PCLK);
    penable = 1; cyc = 2;
    #1;
    while (pready !== 1'b1 && cyc < 40) begin
      chk("wait_slverr", 32'(pslverr), 32'd0);
      chk("wait_prdata", prdata, 32'd0);
      if (mangle) begin pwdata = ~wd; paddr = addr ^ 32'h4; pwrite = !wr; end
      @(negedge PCLK); cyc++; #1;
    end
    rd = prdata; err = pslverr;
    chk("ready_timeout", 32'(pready), 32'd1);
  endtask

  task automatic idle();
    @(negedge PCLK);
    psel = 0; penable = 0;
  endtask

  // scoreboard step: predict, run, compare, update model
  task automatic do_op(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr, input bit mangle,
                       output logic [31:0] rd);
    logic [31:0] exp_q[$];
    bit e; int idx; logic err; int cyc;
    e = m_err(addr, pr, apb4_mode);
    idx = (addr / 4) % 16;
    exp_q.push_back((wr || e) ? 32'd0 : mdl[act][idx]);
    xfer(addr, wr, wd, st, pr, mangle, rd, err, cyc);
    chk("cycles", cyc, 2 + ws[act]);
    chk("pslverr", 32'(err), 32'(e));
    chk("prdata", rd, exp_q.pop_front());
    if (wr && !e) mdl[act][idx] = m_merge(mdl[act][idx], wd, apb4_mode ? st : 4'hf);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mdl[d][i] = '0;
  endtask

  initial begin
    logic [31:0] rd, a;
    bit wr;
    int r, na;
    total = 0; bad = 0; act = 0;
    ws[0] = 0; ws[1] = 3;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    apb4_mode = 1; PRESET = 1;
    clear_model();
    repeat (3) @(negedge PCLK);
    #1;
    chk("rst_pready", 32'(bus0.PREADY), 32'd0);
    chk("rst_pslverr", 32'(bus0.PSLVERR), 32'd0);
    chk("rst_prdata", bus1.PRDATA, 32'd0);
    chk("rst_state", 32'(dbg1), 32'(IDLE));
    @(negedge PCLK); PRESET = 0;

    // zero-wait write then read
    do_op(32'h04, 1, 32'hDEADBEEF, 4'hF, 3'b000, 0, rd);
    do_op(32'h04, 0, 32'h0, 4'hF, 3'b000, 0, rd);
    chk("zw_read", rd, 32'hDEADBEEF);

    // strobes, APB4 then APB3
    do_op(32'h08, 1, 32'h11223344, 4'hF, 3'b000, 0, rd);
    do_op(32'h08, 1, 32'hAABBCCDD, 4'h5, 3'b000, 0, rd);
    do_op(32'h08, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("strb_apb4", rd, 32'h11BB33DD);
    idle(); apb4_mode = 0;
    do_op(32'h08, 1, 32'h11223344, 4'hF, 3'b000, 0, rd);
    do_op(32'h08, 1, 32'hAABBCCDD, 4'h5, 3'b000, 0, rd);
    do_op(32'h08, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("strb_apb3", rd, 32'hAABBCCDD);
    idle(); apb4_mode = 1;

    // errors
    do_op(32'h02, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    do_op(32'h100, 1, 32'h55555555, 4'hF, 3'b000, 0, rd);
    do_op(32'h20, 1, 32'h66666666, 4'hF, 3'b010, 0, rd);
    do_op(32'h20, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("secure_unchanged", rd, 32'h0);
    do_op(32'h00, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("oor_unchanged", rd, 32'h0);

    // back-to-back reads, no idle cycle between them
    do_op(32'h00, 1, 32'h01020304, 4'hF, 3'b000, 0, rd);
    do_op(32'h00, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("b2b_first", rd, 32'h01020304);
    do_op(32'h04, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("b2b_second", rd, 32'hDEADBEEF);
    idle();

    // access phase without setup
    @(negedge PCLK);
    psel = 1; penable = 1; pwrite = 1; paddr = 32'h0; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    #1;
    chk("noset_pready", 32'(pready), 32'd1);
    chk("noset_pslverr", 32'(pslverr), 32'd1);
    idle();
    do_op(32'h00, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("noset_noeffect", rd, 32'h01020304);
    idle();

    // wait states, data changed mid-access
    act = 1;
    do_op(32'h10, 1, 32'hA5A5F00F, 4'hF, 3'b000, 1, rd);
    do_op(32'h10, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("ws_setup_value", rd, 32'hA5A5F00F);
    idle();

    // randomized traffic across both completers
    for (int n = 0; n < 60; n++) begin
      na = int'($urandom_range(0, 1));
      if (na != act || $urandom_range(0, 1) == 1) begin
        idle();
        act = na;
        apb4_mode = 1'($urandom_range(0, 1));
      end
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'h40 << $urandom_range(0, 20);
      else             a = $urandom;
      wr = 1'($urandom_range(0, 1));
      do_op(a, wr, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), rd);
    end
    idle();

    // reset in the middle of a waited write
    act = 1; apb4_mode = 1;
    do_op(32'h0C, 1, 32'h12345678, 4'hF, 3'b000, 0, rd);
    idle();
    @(negedge PCLK);
    psel = 1; penable = 0; paddr = 32'h0C; pwrite = 1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(negedge PCLK); penable = 1;
    @(negedge PCLK); PRESET = 1;
    #1;
    chk("midrst_pready", 32'(pready), 32'd0);
    chk("midrst_prdata", prdata, 32'd0);
    @(negedge PCLK);
    #1;
    chk("midrst_state", 32'(dbg1), 32'(IDLE));
    PRESET = 0; psel = 0; penable = 0;
    clear_model();
    do_op(32'h0C, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("post_rst_reg3", rd, 32'h0);
    idle();
    act = 0;
    do_op(32'h04, 0, 32'h0, 4'h0, 3'b000, 0, rd);
    chk("post_rst_dut0", rd, 32'h0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
